// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: request lengths, FSM states,
// request sources and the IO address prefix.
package mem_ctrl_pkg;

  localparam logic [2:0] REQUIRE8  = 3'd1;
  localparam logic [2:0] REQUIRE16 = 3'd2;
  localparam logic [2:0] REQUIRE32 = 3'd4;

  localparam int unsigned LSBINSTRLEN_W = 3;
  typedef logic [LSBINSTRLEN_W-1:0] lsb_instr_len_t;

  localparam logic [1:0] IO_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_READ,
    MC_WRITE,
    MC_DONE
  } mc_state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_FETCH,
    SRC_STORE
  } mc_src_t;

  // Anything other than a byte or halfword request is serviced as a word.
  function automatic lsb_instr_len_t norm_len(input lsb_instr_len_t len);
    if (len == REQUIRE8 || len == REQUIRE16) return len;
    return REQUIRE32;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO port controller arbitrating the load/store buffer and the
// instruction fetcher; assembles little-endian reads and splits stores.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned IO_BIT_HI = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_wrong,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              if_read_signal,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              mem_if_success,
  output logic [31:0]       mem_if_instr,
  input  logic              lsb_read_signal,
  input  logic              lsb_write_signal,
  input  logic [2:0]        requiring_length,
  input  logic [ADDR_W-1:0] to_mem_addr,
  input  logic [31:0]       to_mem_data,
  output logic              mem_load_success,
  output logic              mem_store_success,
  output logic [31:0]       from_mem_data
);

  mc_state_t        state, state_next;
  mc_src_t          src_q;
  logic [ADDR_W-1:0] base_q;
  lsb_instr_len_t   len_q;
  logic [2:0]       idx_q;
  logic [31:0]      data_q;
  logic [31:0]      rbuf_q;
  logic             io_q;

  logic             req_is_io;
  logic             accept_wr, accept_load, accept_fetch;
  logic             wr_blocked;
  logic [1:0]       rd_pos, wr_cur_pos, wr_nxt_pos;
  logic [31:0]      rd_word;
  logic [7:0]       wr_cur_byte, wr_nxt_byte;

  assign req_is_io  = (to_mem_addr[IO_BIT_HI -: 2] == IO_PREFIX);
  assign wr_blocked = io_q && io_buffer_full;

  always_comb begin
    state_next   = state;
    accept_wr    = 1'b0;
    accept_load  = 1'b0;
    accept_fetch = 1'b0;
    case (state)
      MC_IDLE: begin
        // A stalled IO store keeps ownership of the port; reads wait behind it.
        if (lsb_write_signal) begin
          if (!(req_is_io && io_buffer_full)) begin
            accept_wr  = 1'b1;
            state_next = MC_WRITE;
          end
        end else if (!jump_wrong) begin
          if (lsb_read_signal) begin
            accept_load = 1'b1;
            state_next  = MC_READ;
          end else if (if_read_signal) begin
            accept_fetch = 1'b1;
            state_next   = MC_READ;
          end
        end
      end
      MC_READ: begin
        if (jump_wrong)           state_next = MC_IDLE;
        else if (idx_q == len_q)  state_next = MC_DONE;
      end
      MC_WRITE: begin
        if (mem_wr && idx_q == len_q - 3'd1) state_next = MC_DONE;
      end
      default: state_next = MC_IDLE;
    endcase
  end

  // Byte captured this edge belongs to position idx-1 (idx==4 wraps to 3).
  always_comb begin
    rd_pos     = 2'(idx_q - 3'd1);
    wr_cur_pos = idx_q[1:0];
    wr_nxt_pos = idx_q[1:0] + 2'd1;
    rd_word    = rbuf_q;
    rd_word[{rd_pos, 3'b000} +: 8] = mem_din;
    wr_cur_byte = data_q[{wr_cur_pos, 3'b000} +: 8];
    wr_nxt_byte = data_q[{wr_nxt_pos, 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst)      state <= MC_IDLE;
    else if (rdy) state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q             <= SRC_NONE;
      base_q            <= '0;
      len_q             <= '0;
      idx_q             <= '0;
      data_q            <= '0;
      rbuf_q            <= '0;
      io_q              <= 1'b0;
      mem_a             <= '0;
      mem_wr            <= 1'b0;
      mem_dout          <= '0;
      mem_if_success    <= 1'b0;
      mem_load_success  <= 1'b0;
      mem_store_success <= 1'b0;
      mem_if_instr      <= '0;
      from_mem_data     <= '0;
    end else if (rdy) begin
      mem_if_success    <= 1'b0;
      mem_load_success  <= 1'b0;
      mem_store_success <= 1'b0;
      case (state)
        MC_IDLE: begin
          if (accept_wr) begin
            src_q    <= SRC_STORE;
            base_q   <= to_mem_addr;
            len_q    <= norm_len(requiring_length);
            data_q   <= to_mem_data;
            io_q     <= req_is_io;
            idx_q    <= '0;
            mem_a    <= to_mem_addr;
            mem_dout <= to_mem_data[7:0];
            mem_wr   <= 1'b1;
          end else if (accept_load || accept_fetch) begin
            src_q  <= accept_load ? SRC_LOAD : SRC_FETCH;
            base_q <= accept_load ? to_mem_addr : if_addr;
            len_q  <= accept_load ? norm_len(requiring_length) : REQUIRE32;
            mem_a  <= accept_load ? to_mem_addr : if_addr;
            io_q   <= 1'b0;
            idx_q  <= '0;
            rbuf_q <= '0;
            mem_wr <= 1'b0;
          end
        end
        MC_READ: begin
          mem_wr <= 1'b0;
          if (!jump_wrong) begin
            if (idx_q != 3'd0) rbuf_q <= rd_word;
            if ((idx_q + 3'd1) < len_q) mem_a <= base_q + ADDR_W'(idx_q + 3'd1);
            if (idx_q == len_q) begin
              if (src_q == SRC_FETCH) begin
                mem_if_instr   <= rd_word;
                mem_if_success <= 1'b1;
              end else begin
                from_mem_data    <= rd_word;
                mem_load_success <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        MC_WRITE: begin
          if (mem_wr) begin
            if (idx_q == len_q - 3'd1) begin
              mem_wr            <= 1'b0;
              mem_store_success <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
              if (wr_blocked) begin
                mem_wr <= 1'b0;
              end else begin
                mem_a    <= base_q + ADDR_W'(idx_q + 3'd1);
                mem_dout <= wr_nxt_byte;
              end
            end
          end else if (!wr_blocked) begin
            mem_wr   <= 1'b1;
            mem_a    <= base_q + ADDR_W'(idx_q);
            mem_dout <= wr_cur_byte;
          end
        end
        default: mem_wr <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a synchronous one-cycle-latency RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_read_signal;
  logic [31:0] if_addr;
  logic        mem_if_success;
  logic [31:0] mem_if_instr;
  logic        lsb_read_signal, lsb_write_signal;
  logic [2:0]  requiring_length;
  logic [31:0] to_mem_addr, to_mem_data;
  logic        mem_load_success, mem_store_success;
  logic [31:0] from_mem_data;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] ram [int unsigned];
  logic [7:0] ram_q = 8'h00;

  always #5 clk = ~clk;

  assign mem_din = ram_q;

  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    ram_q <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
  end

  mem_ctrl #(.ADDR_W(32), .IO_BIT_HI(17)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .if_read_signal(if_read_signal),
    .if_addr(if_addr), .mem_if_success(mem_if_success),
    .mem_if_instr(mem_if_instr), .lsb_read_signal(lsb_read_signal),
    .lsb_write_signal(lsb_write_signal), .requiring_length(requiring_length),
    .to_mem_addr(to_mem_addr), .to_mem_data(to_mem_data),
    .mem_load_success(mem_load_success), .mem_store_success(mem_store_success),
    .from_mem_data(from_mem_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sw_bytes [4];

  initial begin
    sw_bytes[0] = 8'hEF; sw_bytes[1] = 8'hBE; sw_bytes[2] = 8'hAD; sw_bytes[3] = 8'hDE;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h2000] = 8'hF0;

    rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0; io_buffer_full = 1'b0;
    if_read_signal = 1'b0; if_addr = '0;
    lsb_read_signal = 1'b0; lsb_write_signal = 1'b0;
    requiring_length = 3'd4; to_mem_addr = '0; to_mem_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_success", {29'd0, mem_if_success, mem_load_success, mem_store_success}, 32'd0);
    check("rst_instr", mem_if_instr, 32'd0);
    check("rst_ldata", from_mem_data, 32'd0);

    // Fetch of a word at 0x100
    if_read_signal = 1'b1; if_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fetch_addr", mem_a, 32'h100 + 32'(i));
      check("fetch_early", {31'd0, mem_if_success}, 32'd0);
    end
    tick();
    check("fetch_e4", {31'd0, mem_if_success}, 32'd0);
    tick();
    check("fetch_done", {31'd0, mem_if_success}, 32'd1);
    check("fetch_instr", mem_if_instr, 32'h00000513);
    if_read_signal = 1'b0;
    tick();
    check("fetch_pulse", {31'd0, mem_if_success}, 32'd0);

    // Load byte contends with fetch; load wins
    lsb_read_signal = 1'b1; requiring_length = 3'd1; to_mem_addr = 32'h2000;
    if_read_signal = 1'b1; if_addr = 32'h100;
    tick();
    check("lb_addr", mem_a, 32'h2000);
    tick();
    check("lb_e1", {31'd0, mem_load_success}, 32'd0);
    tick();
    check("lb_done", {31'd0, mem_load_success}, 32'd1);
    check("lb_data", from_mem_data, 32'h000000F0);
    check("lb_no_fetch", {31'd0, mem_if_success}, 32'd0);
    lsb_read_signal = 1'b0;
    tick();
    check("lb_done_bubble", mem_a, 32'h2000);
    tick();
    check("fetch2_addr", mem_a, 32'h100);
    for (int i = 0; i < 4; i++) tick();
    check("fetch2_e4", {31'd0, mem_if_success}, 32'd0);
    tick();
    check("fetch2_done", {31'd0, mem_if_success}, 32'd1);
    check("fetch2_instr", mem_if_instr, 32'h00000513);
    if_read_signal = 1'b0;
    tick();

    // Store word 0xDEADBEEF to 0x400
    lsb_write_signal = 1'b1; requiring_length = 3'd4;
    to_mem_addr = 32'h400; to_mem_data = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("sw_wr", {31'd0, mem_wr}, 32'd1);
      check("sw_addr", mem_a, 32'h400 + 32'(i));
      check("sw_byte", {24'd0, mem_dout}, {24'd0, sw_bytes[i]});
      check("sw_early", {31'd0, mem_store_success}, 32'd0);
    end
    tick();
    check("sw_wr_off", {31'd0, mem_wr}, 32'd0);
    check("sw_done", {31'd0, mem_store_success}, 32'd1);
    lsb_write_signal = 1'b0;
    tick();
    check("sw_pulse", {31'd0, mem_store_success}, 32'd0);
    check("sw_wr_idle", {31'd0, mem_wr}, 32'd0);

    // Length 3 is serviced as a word; reads back the store
    lsb_read_signal = 1'b1; requiring_length = 3'd3; to_mem_addr = 32'h400;
    for (int i = 0; i < 5; i++) tick();
    check("l3_e4", {31'd0, mem_load_success}, 32'd0);
    tick();
    check("l3_done", {31'd0, mem_load_success}, 32'd1);
    check("l3_data", from_mem_data, 32'hDEADBEEF);
    lsb_read_signal = 1'b0;
    tick();

    // Load halfword at 0x402 with rdy dropped mid-access
    lsb_read_signal = 1'b1; requiring_length = 3'd2; to_mem_addr = 32'h402;
    tick();
    check("lh_addr", mem_a, 32'h402);
    rdy = 1'b0;
    tick(); tick();
    check("rdy_freeze_addr", mem_a, 32'h402);
    check("rdy_freeze_succ", {31'd0, mem_load_success}, 32'd0);
    rdy = 1'b1;
    tick();
    check("lh_addr1", mem_a, 32'h403);
    tick();
    check("lh_e2", {31'd0, mem_load_success}, 32'd0);
    tick();
    check("lh_done", {31'd0, mem_load_success}, 32'd1);
    check("lh_data", from_mem_data, 32'h0000DEAD);
    lsb_read_signal = 1'b0;
    tick();

    // IO store stalled by a full IO buffer
    lsb_write_signal = 1'b1; requiring_length = 3'd1;
    to_mem_addr = 32'h30000; to_mem_data = 32'h00000041; io_buffer_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("io_stall_wr", {31'd0, mem_wr}, 32'd0);
    end
    io_buffer_full = 1'b0;
    tick();
    check("io_wr", {31'd0, mem_wr}, 32'd1);
    check("io_byte", {24'd0, mem_dout}, 32'h41);
    check("io_addr", mem_a, 32'h30000);
    tick();
    check("io_done", {31'd0, mem_store_success}, 32'd1);
    check("io_wr_off", {31'd0, mem_wr}, 32'd0);
    lsb_write_signal = 1'b0;
    tick();

    // Flush two cycles into a load word, then a halfword store
    lsb_read_signal = 1'b1; requiring_length = 3'd4; to_mem_addr = 32'h500;
    tick(); tick(); tick();
    lsb_read_signal = 1'b0; jump_wrong = 1'b1;
    tick();
    check("flush_no_succ", {31'd0, mem_load_success}, 32'd0);
    jump_wrong = 1'b0;
    lsb_write_signal = 1'b1; requiring_length = 3'd2;
    to_mem_addr = 32'h600; to_mem_data = 32'h00001234;
    tick();
    check("sh_wr0", {31'd0, mem_wr}, 32'd1);
    check("sh_byte0", {24'd0, mem_dout}, 32'h34);
    check("sh_addr0", mem_a, 32'h600);
    check("flush_still_none", {31'd0, mem_load_success}, 32'd0);
    tick();
    check("sh_byte1", {24'd0, mem_dout}, 32'h12);
    check("sh_addr1", mem_a, 32'h601);
    tick();
    check("sh_done", {31'd0, mem_store_success}, 32'd1);
    check("sh_wr_off", {31'd0, mem_wr}, 32'd0);
    lsb_write_signal = 1'b0;
    tick();

    // Reset asserted while the second byte of a store is on the bus
    lsb_write_signal = 1'b1; requiring_length = 3'd4;
    to_mem_addr = 32'h700; to_mem_data = 32'h11223344;
    tick(); tick();
    check("rsw_byte1", {24'd0, mem_dout}, 32'h33);
    rst = 1'b1; lsb_write_signal = 1'b0;
    tick();
    check("rsw_wr", {31'd0, mem_wr}, 32'd0);
    check("rsw_addr", mem_a, 32'd0);
    rst = 1'b0;
    tick();
    check("rsw_no_succ", {31'd0, mem_store_success}, 32'd0);
    check("rsw_idle_wr", {31'd0, mem_wr}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
